// File: rtl/maxpool_relu.sv
// maxpool_relu: optional ReLU plus KxK / stride-S max-pooling over a q7 HWC
// feature map held in a synchronous-read RAM; pooled q7 results are written
// into the next layer's input RAM in (oy, ox, c) order.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   en_ctrl       level enable: 1 starts/continues a pass, 0 aborts/releases
//   rd_addr       tap address into the source RAM (data returns one cycle later)
//   rd_data       signed q7 tap data
//   wr_addr       destination address, (oy*DIM_OUT+ox)*CH + c
//   wr_data       pooled (and optionally rectified) q7 result
//   wr_en         one-cycle write strobe per output element
//   finish        pass complete, held until en_ctrl drops
module maxpool_relu #(
  parameter int unsigned DIM_IN  = 32,
  parameter int unsigned DIM_OUT = 16,
  parameter int unsigned CH      = 32,
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned STRIDE  = 2,
  parameter int unsigned PADDING = 0,
  parameter int unsigned RELU    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_ctrl,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        finish
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = $clog2(DIM_IN + 1);
  localparam int unsigned OW = $clog2(DIM_OUT + 1);
  localparam int unsigned CW = $clog2(CH + 1);
  localparam logic signed [DW-1:0] ACC_INIT = 8'sh80;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [OW-1:0]         oy_q, oy_d, ox_q, ox_d;
  logic [CW-1:0]         c_q, c_d;
  logic [IW-1:0]         iy_q, iy_d, ix_q, ix_d;
  logic signed [DW-1:0]  acc_q, acc_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DW-1:0]         wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d, finish_q, finish_d;

  int                    iy_lo, iy_hi, ix_lo, ix_hi;
  int                    n_oy, n_ox, n_c, n_iy, n_ix;
  logic                  first_tap, last_tap, last_elem;
  logic signed [DW-1:0]  fold;

  // First in-range input coordinate of the window for output coordinate o.
  function automatic int win_lo(input int o);
    int s;
    s = o * int'(STRIDE) - int'(PADDING);
    return (s < 0) ? 0 : s;
  endfunction

  // Last in-range input coordinate of the window for output coordinate o.
  function automatic int win_hi(input int o);
    int e;
    e = o * int'(STRIDE) - int'(PADDING) + int'(KSIZE) - 1;
    return (e > int'(DIM_IN) - 1) ? int'(DIM_IN) - 1 : e;
  endfunction

  function automatic logic [AW-1:0] tap_addr(input int iy, input int ix, input int c);
    return AW'((iy * int'(DIM_IN) + ix) * int'(CH) + c);
  endfunction

  // Window bounds, tap position flags and the running max with the returning tap.
  always_comb begin
    iy_lo     = win_lo(int'(oy_q));
    iy_hi     = win_hi(int'(oy_q));
    ix_lo     = win_lo(int'(ox_q));
    ix_hi     = win_hi(int'(ox_q));
    first_tap = (int'(iy_q) == iy_lo) && (int'(ix_q) == ix_lo);
    last_tap  = (int'(iy_q) == iy_hi) && (int'(ix_q) == ix_hi);
    last_elem = (int'(oy_q) == int'(DIM_OUT) - 1) && (int'(ox_q) == int'(DIM_OUT) - 1) &&
                (int'(c_q) == int'(CH) - 1);
    fold      = (acc_q > $signed(rd_data)) ? acc_q : $signed(rd_data);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      oy_q      <= '0;
      ox_q      <= '0;
      c_q       <= '0;
      iy_q      <= '0;
      ix_q      <= '0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      c_q       <= c_d;
      iy_q      <= iy_d;
      ix_q      <= ix_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      finish_q  <= finish_d;
    end
  end

  // Next-state logic; dropping en_ctrl returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en_ctrl) state_d = S_FETCH;
      S_FETCH: begin
        if (!en_ctrl)     state_d = S_IDLE;
        else if (last_tap) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = en_ctrl ? S_WRITE : S_IDLE;
      S_WRITE: begin
        if (!en_ctrl)       state_d = S_IDLE;
        else if (last_elem) state_d = S_DONE;
        else                state_d = S_FETCH;
      end
      S_DONE:  if (!en_ctrl) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter advance, accumulation and registered output values.
  always_comb begin
    oy_d      = oy_q;
    ox_d      = ox_q;
    c_d       = c_q;
    iy_d      = iy_q;
    ix_d      = ix_q;
    acc_d     = acc_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    finish_d  = (state_d == S_DONE);
    n_oy      = int'(oy_q);
    n_ox      = int'(ox_q);
    n_c       = int'(c_q);
    n_iy      = int'(iy_q);
    n_ix      = int'(ix_q);

    unique case (state_q)
      S_FETCH: begin
        // The first cycle of a window has no returning tap yet; seed the max instead.
        acc_d = first_tap ? ACC_INIT : fold;
        if (!last_tap) begin
          if (int'(ix_q) < ix_hi) begin
            n_ix = int'(ix_q) + 1;
          end else begin
            n_ix = ix_lo;
            n_iy = int'(iy_q) + 1;
          end
        end
      end
      S_DRAIN: begin
        wr_data_d = ((RELU != 0) && fold[DW-1]) ? '0 : fold;
        wr_addr_d = AW'((int'(oy_q) * int'(DIM_OUT) + int'(ox_q)) * int'(CH) + int'(c_q));
        wr_en_d   = (state_d == S_WRITE);
      end
      S_WRITE: begin
        if (int'(c_q) < int'(CH) - 1) begin
          n_c = int'(c_q) + 1;
        end else begin
          n_c = 0;
          if (int'(ox_q) < int'(DIM_OUT) - 1) begin
            n_ox = int'(ox_q) + 1;
          end else begin
            n_ox = 0;
            n_oy = int'(oy_q) + 1;
          end
        end
      end
      default: ;
    endcase

    // A fresh window starts at its first in-range tap.
    if (state_q != S_FETCH) begin
      n_iy = win_lo(n_oy);
      n_ix = win_lo(n_ox);
    end

    if (state_d == S_FETCH) begin
      oy_d      = OW'(n_oy);
      ox_d      = OW'(n_ox);
      c_d       = CW'(n_c);
      iy_d      = IW'(n_iy);
      ix_d      = IW'(n_ix);
      rd_addr_d = tap_addr(n_iy, n_ix, n_c);
    end else if (state_d == S_IDLE) begin
      oy_d      = '0;
      ox_d      = '0;
      c_d       = '0;
      iy_d      = '0;
      ix_d      = '0;
      rd_addr_d = '0;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign finish  = finish_q;

endmodule

// File: tb/tb_maxpool_relu.sv
// Scoreboard bench for maxpool_relu: two small 4x4 instances (RELU off/on)
// and one 32x32 / 4-channel instance exercising edge clipping.
module tb_maxpool_relu;

  typedef struct {
    int addr;
    int data;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c, en_a, en_b, en_c;
  logic [15:0] rd_addr_a, rd_addr_b, rd_addr_c, wr_addr_a, wr_addr_b, wr_addr_c;
  logic [7:0]  rd_data_a, rd_data_b, rd_data_c, wr_data_a, wr_data_b, wr_data_c;
  logic        wr_en_a, wr_en_b, wr_en_c, finish_a, finish_b, finish_c;

  logic [7:0]  mem_s [16];
  logic [7:0]  mem_c [4096];

  exp_t q_a[$], q_b[$], q_c[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_c = 0;
  int   oob_a = 0, oob_b = 0, oob_c = 0;

  maxpool_relu #(.DIM_IN(4), .DIM_OUT(2), .CH(1), .KSIZE(2), .STRIDE(2), .PADDING(0), .RELU(0)) u_a (
    .clk(clk), .reset(rst_a), .en_ctrl(en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .finish(finish_a));

  maxpool_relu #(.DIM_IN(4), .DIM_OUT(2), .CH(1), .KSIZE(2), .STRIDE(2), .PADDING(0), .RELU(1)) u_b (
    .clk(clk), .reset(rst_b), .en_ctrl(en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .finish(finish_b));

  maxpool_relu #(.DIM_IN(32), .DIM_OUT(16), .CH(4), .KSIZE(3), .STRIDE(2), .PADDING(0), .RELU(1)) u_c (
    .clk(clk), .reset(rst_c), .en_ctrl(en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_en(wr_en_c), .finish(finish_c));

  // Synchronous-read RAM models and a free-running cycle counter.
  always @(posedge clk) begin
    rd_data_a <= mem_s[rd_addr_a[3:0]];
    rd_data_b <= mem_s[rd_addr_b[3:0]];
    rd_data_c <= mem_c[rd_addr_c[11:0]];
    cyc       <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int addr);
    checks++;
    errors++;
    $display("FAIL %s: write to %0d with no expected entry", name, addr);
  endtask

  // Monitors: pop and compare on every write strobe; track read-address range.
  always @(negedge clk) begin
    exp_t e;
    if (rd_addr_a >= 16'd16)   oob_a++;
    if (rd_addr_b >= 16'd16)   oob_b++;
    if (rd_addr_c >= 16'd4096) oob_c++;
    if (wr_en_a) begin
      if (q_a.size() == 0) unexpected("a_write", int'(wr_addr_a));
      else begin
        e = q_a.pop_front();
        check("a_addr", int'(wr_addr_a), e.addr);
        check("a_data", int'($signed(wr_data_a)), e.data);
      end
    end
    if (wr_en_b) begin
      if (q_b.size() == 0) unexpected("b_write", int'(wr_addr_b));
      else begin
        e = q_b.pop_front();
        check("b_addr", int'(wr_addr_b), e.addr);
        check("b_data", int'($signed(wr_data_b)), e.data);
      end
    end
    if (wr_en_c) begin
      if (q_c.size() == 0) unexpected("c_write", int'(wr_addr_c));
      else begin
        e = q_c.pop_front();
        check("c_addr", int'(wr_addr_c), e.addr);
        check("c_data", int'($signed(wr_data_c)), e.data);
        if (e.gap != 0) check("c_gap", cyc - last_c, e.gap);
      end
      last_c = cyc;
    end
  end

  task automatic push(input int sel, input int addr, input int data, input int gap);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.gap  = gap;
    case (sel)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  // Cycles from the start edge until finish is seen; -1 on timeout.
  task automatic wait_fin(input int sel, input int budget, output int lat);
    logic f;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      f = (sel == 0) ? finish_a : (sel == 1) ? finish_b : finish_c;
      if (f) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic fill_s(input int kind, input int val);
    for (int i = 0; i < 16; i++) mem_s[i] = (kind == 0) ? 8'(i) : 8'(val);
  endtask

  initial begin
    int lat, n, ws, nx, ny;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    fill_s(0, 0);
    for (int i = 0; i < 4096; i++) mem_c[i] = 8'(i % 4);
    repeat (3) @(negedge clk);
    check("rst_rd_addr", int'(rd_addr_a), 0);
    check("rst_wr_addr", int'(wr_addr_a), 0);
    check("rst_wr_data", int'(wr_data_a), 0);
    check("rst_wr_en", int'(wr_en_a), 0);
    check("rst_finish", int'(finish_a), 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // T1: ramp, 2x2 windows -> 5,7,13,15; finish 24 cycles after start, held while enabled.
    push(0, 0, 5, 0); push(0, 1, 7, 0); push(0, 2, 13, 0); push(0, 3, 15, 0);
    en_a = 1'b1;
    wait_fin(0, 200, lat);
    check("t1_latency", lat, 24);
    repeat (5) @(negedge clk);
    check("t1_finish_held", int'(finish_a), 1);
    en_a = 1'b0;
    @(negedge clk);
    check("t1_finish_release", int'(finish_a), 0);

    // T6: reset mid-FETCH with en_ctrl still high clears every output.
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_mid_rd_addr", int'(rd_addr_a), 4);
    rst_a = 1'b0;
    @(negedge clk);
    check("t6_rd_addr", int'(rd_addr_a), 0);
    check("t6_wr_addr", int'(wr_addr_a), 0);
    check("t6_wr_data", int'(wr_data_a), 0);
    check("t6_wr_en", int'(wr_en_a), 0);
    check("t6_finish", int'(finish_a), 0);
    @(negedge clk);
    check("t6_hold_rd_addr", int'(rd_addr_a), 0);
    en_a = 1'b0;
    rst_a = 1'b1;
    @(negedge clk);

    // T5: abort after the third write, then restart from address 0.
    push(0, 0, 5, 0); push(0, 1, 7, 0); push(0, 2, 13, 0);
    en_a = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(negedge clk);
      if (wr_en_a) n++;
    end
    check("t5_three_writes", n, 3);
    en_a = 1'b0;
    ws = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_en_a) ws++;
    end
    check("t5_no_fourth_write", ws, 0);
    check("t5_finish_low", int'(finish_a), 0);
    push(0, 0, 5, 0); push(0, 1, 7, 0); push(0, 2, 13, 0); push(0, 3, 15, 0);
    en_a = 1'b1;
    wait_fin(0, 200, lat);
    check("t5_restart_latency", lat, 24);
    en_a = 1'b0;
    @(negedge clk);

    // T2: all -5 -> 0xFB without ReLU, 0 with ReLU.
    fill_s(1, -5);
    for (int i = 0; i < 4; i++) begin
      push(0, i, -5, 0);
      push(1, i, 0, 0);
    end
    en_a = 1'b1; en_b = 1'b1;
    wait_fin(0, 200, lat);
    check("t2_latency", lat, 24);
    check("t2_finish_b", int'(finish_b), 1);
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);

    // T3: all -128 -> -128 without ReLU (seed value equals every tap).
    fill_s(1, -128);
    for (int i = 0; i < 4; i++) begin
      push(0, i, -128, 0);
      push(1, i, 0, 0);
    end
    en_a = 1'b1; en_b = 1'b1;
    wait_fin(0, 200, lat);
    check("t3_latency", lat, 24);
    en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);

    // T4: 32x32x4 map of channel index; edge windows clip to 2 taps per axis.
    for (int oy = 0; oy < 16; oy++)
      for (int ox = 0; ox < 16; ox++)
        for (int c = 0; c < 4; c++) begin
          nx = (ox == 15) ? 2 : 3;
          ny = (oy == 15) ? 2 : 3;
          push(2, (oy * 16 + ox) * 4 + c, c, (oy == 0 && ox == 0 && c == 0) ? 0 : nx * ny + 2);
        end
    en_c = 1'b1;
    wait_fin(2, 12000, lat);
    check("t4_latency", lat, 10884);
    en_c = 1'b0;
    @(negedge clk);
    check("t4_finish_release", int'(finish_c), 0);

    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);
    check("queue_c_empty", q_c.size(), 0);
    check("rd_range_a", oob_a, 0);
    check("rd_range_b", oob_b, 0);
    check("rd_range_c", oob_c, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
